// File: rtl/trigger_stop_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trigger_stop_ctrl_pkg
// Shared constants for the logic-analyzer trigger/stop controller:
//   - FSM state encodings (also the encoding of the 'state' status output)
//   - trigger mode codes carried on i_mode
// -----------------------------------------------------------------------------
package trigger_stop_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_HOLDOFF = 2'b10;
    localparam logic [1:0] ST_STOPPED = 2'b11;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_ANY   = 2'b11;

endpackage

// File: rtl/trigger_match.sv
// -----------------------------------------------------------------------------
// trigger_match
// Pattern/edge detector for the probe channels. Keeps a one-cycle history of
// the probes so that edge modes can compare the current sample against the
// previous one.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_probe      sampled probe channels
//   i_mask       1 = channel participates in the match
//   i_pattern    required value per masked channel
//   i_mode       LEVEL / RISE / FALL / ANY_CHANGE
//   o_match      combinational match for the current cycle
// -----------------------------------------------------------------------------
module trigger_match
    import trigger_stop_ctrl_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_probe,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [NUM_CH-1:0] i_pattern,
    input  logic [1:0]        i_mode,
    output logic              o_match
);

    logic [NUM_CH-1:0] prev_probe_q, prev_probe_d;
    logic              prev_valid_q, prev_valid_d;

    logic lvl_now;
    logic lvl_prev;
    logic any_chg;
    logic mode_match;

    always_comb begin
        prev_probe_d = i_probe;
        prev_valid_d = 1'b1;

        lvl_now  = &(~(i_probe ^ i_pattern) | ~i_mask);
        lvl_prev = &(~(prev_probe_q ^ i_pattern) | ~i_mask);
        any_chg  = |((i_probe ^ prev_probe_q) & i_mask);

        mode_match = 1'b0;
        case (i_mode)
            MODE_LEVEL: mode_match = lvl_now;
            MODE_RISE:  mode_match = prev_valid_q & lvl_now & ~lvl_prev;
            MODE_FALL:  mode_match = prev_valid_q & ~lvl_now & lvl_prev;
            MODE_ANY:   mode_match = prev_valid_q & any_chg;
            default:    mode_match = 1'b0;
        endcase

        // An all-zero mask would make LEVEL trivially true; treat it as
        // "pattern trigger disabled" instead.
        o_match = mode_match & (|i_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_probe_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_probe_q <= prev_probe_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/trigger_stop_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_stop_ctrl
// Trigger/stop controller for the internal logic-analyzer capture path.
// Once primed, waits for a probe match (or forced trigger), records the buffer
// write address, runs a holdoff and then asserts 'stopped' to freeze capture.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   primed       capture memory filled; trigger allowed
//   i_rearm      pulse: return to IDLE from any state
//   i_force      pulse: unconditional trigger while ARMED
//   i_probe      sampled probe channels
//   i_mask       channel participation mask
//   i_pattern    required value per masked channel
//   i_mode       trigger mode (LEVEL/RISE/FALL/ANY_CHANGE)
//   i_holdoff    cycles from trigger to stop, latched at trigger
//   i_wr_addr    current capture write address
//   triggered    sticky trigger flag (registered)
//   stopped      holdoff expired (registered)
//   trig_addr    i_wr_addr captured on the trigger cycle
//   state        FSM state for status readback
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the capture memory to be primed
// ARMED   | looking for a match or forced trigger
// HOLDOFF | triggered, counting post-trigger cycles
// STOPPED | holdoff done, capture frozen until rearm
// -----------------------------------------------------------------------------
module trigger_stop_ctrl
    import trigger_stop_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     primed,
    input  logic                     i_rearm,
    input  logic                     i_force,
    input  logic [NUM_CH-1:0]        i_probe,
    input  logic [NUM_CH-1:0]        i_mask,
    input  logic [NUM_CH-1:0]        i_pattern,
    input  logic [1:0]               i_mode,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
    output logic                     triggered,
    output logic                     stopped,
    output logic [ADDR_WIDTH-1:0]    trig_addr,
    output logic [1:0]               state
);

    logic [1:0]               state_q, state_d;
    logic                     triggered_q, triggered_d;
    logic                     stopped_q, stopped_d;
    logic [ADDR_WIDTH-1:0]    trig_addr_q, trig_addr_d;
    logic [HOLDOFF_WIDTH-1:0] counter_q, counter_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;

    logic match;
    logic hit;

    trigger_match #(
        .NUM_CH (NUM_CH)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .i_probe   (i_probe),
        .i_mask    (i_mask),
        .i_pattern (i_pattern),
        .i_mode    (i_mode),
        .o_match   (match)
    );

    assign hit = (state_q == ST_ARMED) & (match | i_force);

    always_comb begin
        state_d     = state_q;
        triggered_d = triggered_q;
        stopped_d   = stopped_q;
        trig_addr_d = trig_addr_q;
        counter_d   = counter_q;
        holdoff_d   = holdoff_q;

        if (i_rearm) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
            stopped_d   = 1'b0;
            counter_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (primed) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // A hit takes priority over primed dropping in the same cycle.
                    if (hit) begin
                        triggered_d = 1'b1;
                        trig_addr_d = i_wr_addr;
                        holdoff_d   = i_holdoff;
                        counter_d   = '0;
                        if (i_holdoff == '0) begin
                            state_d   = ST_STOPPED;
                            stopped_d = 1'b1;
                        end else begin
                            state_d = ST_HOLDOFF;
                        end
                    end else if (!primed) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    // Terminal compare at H-1 makes stopped rise H cycles after
                    // triggered; the counter never reaches H, so H = max is safe.
                    if (counter_q == holdoff_q - 1'b1) begin
                        state_d   = ST_STOPPED;
                        stopped_d = 1'b1;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
                ST_STOPPED: begin
                    state_d = ST_STOPPED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            triggered_q <= 1'b0;
            stopped_q   <= 1'b0;
            trig_addr_q <= '0;
            counter_q   <= '0;
            holdoff_q   <= '0;
        end else begin
            state_q     <= state_d;
            triggered_q <= triggered_d;
            stopped_q   <= stopped_d;
            trig_addr_q <= trig_addr_d;
            counter_q   <= counter_d;
            holdoff_q   <= holdoff_d;
        end
    end

    assign triggered = triggered_q;
    assign stopped   = stopped_q;
    assign trig_addr = trig_addr_q;
    assign state     = state_q;

endmodule
